// File: rtl/ahb_pkg.sv
// Shared AHB-lite types: transfer encodings, response codes and slave FSM states.
// Also provides the little-endian byte-lane helper used by the slave.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } slv_state_t;

   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << addr_lo;
         HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: mask = 4'b1111;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised backing store: per-byte write enables on the clock edge,
// combinational read of the addressed word.
module ahb_slave_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int IDX_W     = 8
) (
   input  logic             hclk,
   input  logic [IDX_W-1:0] addr,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [MEM_DEPTH];

   always_ff @(posedge hclk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave.sv
// Memory-backed AHB-lite responder with configurable wait states and a
// two-cycle ERROR response for misaligned, oversized or out-of-range accesses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no data phase pending; ready, OKAY
// ST_WAIT   | legal transfer stalled; counter runs down to 0
// ST_ACCESS | final data-phase cycle; write commits / read data driven
// ST_ERR1   | first ERROR cycle, hreadyout low
// ST_ERR2   | second ERROR cycle, hreadyout high; may accept next transfer
module ahb_lite_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hreadyout,
   output logic                  hresp
);
   import ahb_pkg::*;

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

   htrans_t          trans;
   slv_state_t       state_q, state_nxt;
   logic [3:0]       cnt_q, cnt_nxt;
   logic [IDX_W-1:0] addr_q;
   logic             write_q;
   logic [3:0]       mask_q;
   logic             addr_ready, accept, illegal, rd_phase;
   logic [3:0]       mem_we;
   logic [31:0]      mem_rdata, hrdata_q;
   logic             unused_hburst;

   // Burst type carries no information here: each beat decodes its own haddr.
   assign unused_hburst = ^hburst;

   assign trans      = htrans_t'(htrans);
   assign addr_ready = (state_q == ST_IDLE) || (state_q == ST_ACCESS) || (state_q == ST_ERR2);
   assign accept     = hsel && hready && addr_ready &&
                       ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

   always_comb begin
      illegal = 1'b0;
      if (hsize > HSIZE_WORD) begin
         illegal = 1'b1;
      end
      if ((hsize == HSIZE_HALF) && haddr[0]) begin
         illegal = 1'b1;
      end
      if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) begin
         illegal = 1'b1;
      end
      if (haddr[ADDR_WIDTH-1:2] >= DEPTH_WORDS) begin
         illegal = 1'b1;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         mask_q   <= 4'b0000;
         hrdata_q <= 32'd0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         if (accept) begin
            addr_q  <= haddr[IDX_W+1:2];
            write_q <= hwrite && !illegal;
            mask_q  <= illegal ? 4'b0000 : lane_mask(hsize, haddr[1:0]);
         end
         if (rd_phase) begin
            hrdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      case (state_q)
         ST_WAIT: begin
            hreadyout = 1'b0;
            if (cnt_q == 4'd0) begin
               state_nxt = ST_ACCESS;
            end else begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            hresp = HRESP_ERROR;
         end
         default: begin
         end
      endcase
      // IDLE, ACCESS and ERR2 all end with hreadyout high, so each can take a new address phase.
      if (addr_ready) begin
         if (!accept) begin
            state_nxt = ST_IDLE;
         end else if (illegal) begin
            state_nxt = ST_ERR1;
         end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
         end else begin
            state_nxt = ST_ACCESS;
         end
      end
   end

   assign rd_phase = (state_q == ST_ACCESS) && !write_q;
   assign mem_we   = ((state_q == ST_ACCESS) && write_q && hresetn) ? mask_q : 4'b0000;

   ahb_slave_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_mem (
      .hclk  (hclk),
      .addr  (addr_q),
      .we    (mem_we),
      .wdata (hwdata[31:0]),
      .rdata (mem_rdata)
   );

   assign hrdata = rd_phase ? mem_rdata : hrdata_q;

endmodule

// File: tb/tb_ahb_lite_slave.sv
// Directed bench for ahb_lite_slave: a per-cycle vector table against a zero-wait
// instance, plus hand sequences for wait states and reset during WAIT.
module tb_ahb_lite_slave;
   import ahb_pkg::*;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel0, hsel2, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [31:0] hrdata0, hrdata2;
   logic        rdy0, rdy2, resp0, resp2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 hclk = ~hclk;

   ahb_lite_slave #(.WAIT_STATES(0)) u_ws0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(rdy0),
      .hrdata(hrdata0), .hreadyout(rdy0), .hresp(resp0)
   );

   ahb_lite_slave #(.WAIT_STATES(2)) u_ws2 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(rdy2),
      .hrdata(hrdata2), .hreadyout(rdy2), .hresp(resp2)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  tr;
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        rsp;
      logic        chk_d;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic wr,
                              input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                              input logic rdy, input logic rsp, input logic chk, input logic [31:0] rd);
      vec_t r;
      r.sel = sel; r.tr = tr; r.wr = wr; r.sz = sz; r.addr = addr; r.wdata = wd;
      r.rdy = rdy; r.rsp = rsp; r.chk_d = chk; r.rdata = rd;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic xfer2(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output int lows, output logic [31:0] rd, output logic rsp);
      hsel2 = 1'b1; htrans = 2'd2; hwrite = wr; hsize = 3'd2; haddr = a;
      @(posedge hclk); #1;
      hsel2 = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = wd;
      lows = 0; rd = 32'd0; rsp = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge hclk);
         if (rdy2) begin
            rd  = hrdata2;
            rsp = resp2;
            break;
         end
         lows++;
         @(posedge hclk); #1;
      end
      @(posedge hclk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;
   localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2;

   initial begin
      int          lows;
      logic [31:0] rd;
      logic        rsp;

      //            sel tr  wr sz    addr          wdata          rdy rsp chk rdata
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'h0000_0000));
      vecs.push_back(v(1, NS, 1, W, 32'h010, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h010, 32'hDEAD_BEEF, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 1, W, 32'h010, 32'h0000_0000, 1, 0, 1, 32'hDEAD_BEEF));
      vecs.push_back(v(1, NS, 1, B, 32'h013, 32'h1122_3344, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h010, 32'hAA00_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'hAA22_3344));
      vecs.push_back(v(1, NS, 1, W, 32'h000, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, SQ, 1, W, 32'h004, 32'h1111_1111, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, SQ, 1, W, 32'h008, 32'h2222_2222, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, SQ, 1, W, 32'h00C, 32'h3333_3333, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h000, 32'h4444_4444, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, SQ, 0, W, 32'h004, 32'h0000_0000, 1, 0, 1, 32'h1111_1111));
      vecs.push_back(v(1, SQ, 0, W, 32'h008, 32'h0000_0000, 1, 0, 1, 32'h2222_2222));
      vecs.push_back(v(1, SQ, 0, W, 32'h00C, 32'h0000_0000, 1, 0, 1, 32'h3333_3333));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'h4444_4444));
      vecs.push_back(v(1, NS, 1, H, 32'h006, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'hBEEF_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h004, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'hBEEF_2222));
      vecs.push_back(v(1, BZ, 0, W, 32'h000, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'hBEEF_2222));
      vecs.push_back(v(0, NS, 1, W, 32'h000, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'hFFFF_FFFF, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h000, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'h1111_1111));
      vecs.push_back(v(1, NS, 0, W, 32'h002, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 0, 1, 0, 32'h0));
      vecs.push_back(v(1, NS, 1, W, 32'h400, 32'h0000_0000, 1, 1, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'hFFFF_FFFF, 0, 1, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h000, 32'h0000_0000, 1, 1, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'h1111_1111));
      vecs.push_back(v(1, NS, 0, 3'd3, 32'h000, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 0, 1, 0, 32'h0));
      vecs.push_back(v(1, NS, 1, H, 32'h001, 32'h0000_0000, 1, 1, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'hFFFF_FFFF, 0, 1, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h000, 32'h0000_0000, 1, 1, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'h1111_1111));
      vecs.push_back(v(1, NS, 1, W, 32'h3FC, 32'h0000_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 0, W, 32'h3FC, 32'h5A5A_5A5A, 1, 0, 0, 32'h0));
      vecs.push_back(v(1, NS, 1, B, 32'h3FF, 32'h0000_0000, 1, 0, 1, 32'h5A5A_5A5A));
      vecs.push_back(v(1, NS, 0, W, 32'h3FC, 32'hC300_0000, 1, 0, 0, 32'h0));
      vecs.push_back(v(0, ID, 0, W, 32'h000, 32'h0000_0000, 1, 0, 1, 32'hC35A_5A5A));

      hresetn = 1'b0;
      hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'd0; hwrite = 1'b0;
      hsize = 3'd2; hburst = 3'd0; haddr = 32'd0; hwdata = 32'd0;
      repeat (3) @(posedge hclk);
      #1;
      hresetn = 1'b1;

      @(negedge hclk);
      check("ws2 reset hreadyout", {31'd0, rdy2}, 32'd1);
      check("ws2 reset hrdata", hrdata2, 32'd0);
      @(posedge hclk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         hsel0  = vecs[i].sel;
         htrans = vecs[i].tr;
         hwrite = vecs[i].wr;
         hsize  = vecs[i].sz;
         haddr  = vecs[i].addr;
         hwdata = vecs[i].wdata;
         hburst = (vecs[i].tr == SQ) ? 3'd3 : 3'd0;
         @(negedge hclk);
         check($sformatf("row %0d hreadyout", i), {31'd0, rdy0}, {31'd0, vecs[i].rdy});
         check($sformatf("row %0d hresp", i), {31'd0, resp0}, {31'd0, vecs[i].rsp});
         if (vecs[i].chk_d) begin
            check($sformatf("row %0d hrdata", i), hrdata0, vecs[i].rdata);
         end
         @(posedge hclk); #1;
      end
      hsel0 = 1'b0; htrans = 2'd0; hwrite = 1'b0; hburst = 3'd0;

      xfer2(1'b1, 32'h20, 32'hCAFE_F00D, lows, rd, rsp);
      check("ws2 write wait cycles", lows, 2);
      xfer2(1'b0, 32'h20, 32'h0, lows, rd, rsp);
      check("ws2 read wait cycles", lows, 2);
      check("ws2 read hrdata", rd, 32'hCAFE_F00D);
      check("ws2 read hresp", {31'd0, rsp}, 32'd0);
      xfer2(1'b1, 32'h24, 32'h0BAD_C0DE, lows, rd, rsp);
      check("ws2 write2 wait cycles", lows, 2);

      hsel2 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h24;
      @(posedge hclk); #1;
      hsel2 = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 32'h1234_5678; hresetn = 1'b0;
      @(negedge hclk);
      check("ws2 in wait hreadyout", {31'd0, rdy2}, 32'd0);
      @(posedge hclk); #1;
      hresetn = 1'b1;
      @(negedge hclk);
      check("post-reset hreadyout", {31'd0, rdy2}, 32'd1);
      check("post-reset hresp", {31'd0, resp2}, 32'd0);
      check("post-reset hrdata", hrdata2, 32'd0);
      check("post-reset ws0 hrdata", hrdata0, 32'd0);
      @(posedge hclk); #1;

      xfer2(1'b0, 32'h24, 32'h0, lows, rd, rsp);
      check("aborted write left memory", rd, 32'h0BAD_C0DE);
      check("aborted write read waits", lows, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
